lcd_word_writer: RTL and testbench
==================================

LCD_WORD_WRITER -- requirements
Module: lcd_word_writer

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 750000; power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter EN_PULSE_CYC, default 25; lcd_en high width in cycles.
REQ-003 SHALL have parameter CMD_WAIT_CYC, default 2500; post-byte wait for all bytes except clear.
REQ-004 SHALL have parameter CLEAR_WAIT_CYC, default 100000; post-byte wait after clear command 0x01.
REQ-005 SHALL have parameter START_COL, default 5; line-1 column of the first character (0-15).
REQ-006 SHALL have clk, input, 1, the only clock, with all logic on its rising edge.
REQ-007 SHALL have rst_n, input, 1, reset that is asynchronous and active-low.
REQ-008 SHALL have chars, input, 48, six ASCII bytes {char5..char0} from gesture_to_word; char5 is leftmost.
REQ-009 SHALL have start, input, 1, single-cycle request to write chars; honoured only while ready=1.
REQ-010 SHALL have ready, output, 1, high only in IDLE.
REQ-011 SHALL have done, output, 1, one-cycle pulse when the six-character write completes.
REQ-012 SHALL have lcd_rs, output, 1, HD44780 register select: 0 = command, 1 = data.
REQ-013 SHALL have lcd_rw, output, 1, tied to 0 (write only).
REQ-014 SHALL have lcd_en, output, 1, HD44780 enable strobe.
REQ-015 SHALL have lcd_data, output, 8, HD44780 8-bit data bus.

Function
REQ-016 SHALL use FSM states PWRUP, INIT, IDLE, WR_ADDR, WR_CHAR, DONE.
REQ-017 SHALL make every byte transfer one SETUP cycle (rs/data driven, en=0), then EN_PULSE_CYC cycles with en=1, then the wait cycles with en=0.
REQ-018 SHALL hold lcd_rs and lcd_data stable for the whole byte transfer.
REQ-019 SHALL use CLEAR_WAIT_CYC as the wait for byte 0x01 and CMD_WAIT_CYC for every other byte.
REQ-020 SHALL count POWERUP_CYC cycles in PWRUP with en=0, then enter INIT.
REQ-021 SHALL send in INIT, in order: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry increment), all with rs=0, then enter IDLE.
REQ-022 SHALL, in IDLE with start=1, latch chars into an internal register and enter WR_ADDR the same edge.
REQ-023 SHALL ignore start in any state other than IDLE, with no queuing.
REQ-024 SHALL make changes on chars after the latch edge have no effect on the write in progress.
REQ-025 SHALL send in WR_ADDR the byte 0x80 | START_COL[3:0] with rs=0.
REQ-026 SHALL send in WR_CHAR six bytes with rs=1, in the order char5, char4, char3, char2, char1, char0, using a 3-bit index that counts 0..5 and does not wrap.
REQ-027 SHALL pass each character byte through unmodified, with no validity filtering.
REQ-028 SHALL enter DONE after the wait of char0; DONE lasts one cycle with done=1, then the FSM returns to IDLE.
REQ-029 SHALL keep ready=0 in DONE.
REQ-030 SHALL make one write take exactly 7*(1+EN_PULSE_CYC+CMD_WAIT_CYC) cycles from the start-sampling edge to the edge that enters DONE.
REQ-031 SHALL use a single shared cycle counter of at least 20 bits, reloaded at each phase boundary, with no overflow for the default parameters.
REQ-032 SHALL allow back-to-back writes, with a start accepted on the first IDLE cycle after DONE.

Reset
REQ-033 SHALL, while rst_n=0, force state=PWRUP, counters=0, latched chars=0x20 x6, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, ready=0, done=0.
REQ-034 SHALL make reset asserted mid-transfer force lcd_en=0 immediately, without waiting for clk, and restart the full PWRUP+INIT sequence after release.

Verification
REQ-035 SHALL cover: parameters POWERUP=10, EN=2, CMD=4, CLEAR=8, release reset -> ready rises exactly 42 cycles later; bytes seen on en rising edges are 0x38, 0x0C, 0x01, 0x06 with rs=0.
REQ-036 SHALL cover: chars=" WATER", start pulse in IDLE -> en strobes carry 0x85 (rs=0), then 0x20, 0x57, 0x41, 0x54, 0x45, 0x52 (rs=1); done pulses once at cycle 49; ready low for the whole write.
REQ-037 SHALL cover: chars changed to "THANKS" and start re-pulsed mid-write -> no effect; the output stays " WATER" and exactly one done pulse occurs.
REQ-038 SHALL cover: start held high continuously -> back-to-back writes, each 49 cycles plus 1 DONE cycle, each with a single done pulse.
REQ-039 SHALL cover: rst_n low during the en-high phase of char 3 -> lcd_en=0 asynchronously; after release the 42-cycle init repeats with no stray strobes.
REQ-040 SHALL cover: start during PWRUP/INIT -> ignored; no WR_ADDR strobe occurs before ready=1.

Source files
------------

// File: rtl/lcd_word_writer.sv
// HD44780 8-bit-bus writer: power-up wait, 4-byte init, then on request
// positions the cursor on line 1 and writes six latched ASCII characters.
module lcd_word_writer #(
  parameter int POWERUP_CYC    = 750000,
  parameter int EN_PULSE_CYC   = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000,
  parameter int START_COL      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] chars,
  input  logic        start,
  output logic        ready,
  output logic        done,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data
);

  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [7:0]       ADDR_CMD = 8'h80 | 8'(START_COL % 16);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, WR_ADDR, WR_CHAR, DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t           state;
  phase_t           ph;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [47:0]      chars_q;
  logic [CNT_W-1:0] wait_last;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // index 0 is the leftmost character (char5)
  function automatic logic [7:0] char_at(input logic [47:0] c, input logic [2:0] i);
    case (i)
      3'd0:    return c[47:40];
      3'd1:    return c[39:32];
      3'd2:    return c[31:24];
      3'd3:    return c[23:16];
      3'd4:    return c[15:8];
      default: return c[7:0];
    endcase
  endfunction

  // only the clear command needs the long settle time; data 0x01 does not
  assign wait_last = (!lcd_rs && lcd_data == 8'h01) ? CLR_LAST : CMD_LAST;
  assign lcd_rw    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PWRUP;
      ph       <= PH_SETUP;
      cnt      <= '0;
      idx      <= '0;
      chars_q  <= {6{8'h20}};
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      ready    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        PWRUP: begin
          if (cnt == PWR_LAST) begin
            state    <= INIT;
            idx      <= '0;
            ph       <= PH_SETUP;
            cnt      <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_byte(3'd0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            chars_q  <= chars;
            state    <= WR_ADDR;
            ready    <= 1'b0;
            ph       <= PH_SETUP;
            cnt      <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= ADDR_CMD;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          // shared byte engine for INIT / WR_ADDR / WR_CHAR
          case (ph)
            PH_SETUP: begin
              lcd_en <= 1'b1;
              ph     <= PH_PULSE;
              cnt    <= EN_LAST;
            end
            PH_PULSE: begin
              if (cnt == '0) begin
                lcd_en <= 1'b0;
                ph     <= PH_WAIT;
                cnt    <= wait_last;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            default: begin
              if (cnt != '0) begin
                cnt <= cnt - 1'b1;
              end else begin
                ph  <= PH_SETUP;
                cnt <= '0;
                case (state)
                  INIT: begin
                    if (idx == 3'd3) begin
                      state <= IDLE;
                      ready <= 1'b1;
                      idx   <= '0;
                    end else begin
                      idx      <= idx + 3'd1;
                      lcd_data <= init_byte(idx + 3'd1);
                    end
                  end
                  WR_ADDR: begin
                    state    <= WR_CHAR;
                    idx      <= '0;
                    lcd_rs   <= 1'b1;
                    lcd_data <= char_at(chars_q, 3'd0);
                  end
                  default: begin
                    if (idx == 3'd5) begin
                      state <= DONE;
                      done  <= 1'b1;
                      idx   <= '0;
                    end else begin
                      idx      <= idx + 3'd1;
                      lcd_data <= char_at(chars_q, idx + 3'd1);
                    end
                  end
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_word_writer.sv
// Bench for lcd_word_writer: timeline model of expected bus activity checked
// every cycle, plus literal checks of strobe bytes, latencies and resets.
module tb_lcd_word_writer;
  localparam int PW = 10, EN = 2, CMD = 4, CLR = 8, COL = 5;
  localparam int BYTE_CYC  = 1 + EN + CMD;
  localparam int INIT_CYC  = PW + 3 * BYTE_CYC + (1 + EN + CLR);
  localparam int WRITE_CYC = 7 * BYTE_CYC;
  localparam logic [7:0] IB [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [47:0] chars = '0;
  logic        ready, done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;

  lcd_word_writer #(.POWERUP_CYC(PW), .EN_PULSE_CYC(EN), .CMD_WAIT_CYC(CMD),
                    .CLEAR_WAIT_CYC(CLR), .START_COL(COL)) dut (
    .clk(clk), .rst_n(rst_n), .chars(chars), .start(start), .ready(ready),
    .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // model: 0 = power-up/init, 1 = idle, 2 = write; m_t = edges since mode entry
  int          m_mode, m_t;
  logic [47:0] m_chars;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_t <= 0; m_chars <= {6{8'h20}};
    end else begin
      case (m_mode)
        0: begin m_t <= m_t + 1; if (m_t + 1 == INIT_CYC) m_mode <= 1; end
        1: if (start) begin m_mode <= 2; m_t <= 0; m_chars <= chars; end
        default: begin m_t <= m_t + 1; if (m_t + 1 == WRITE_CYC + 1) m_mode <= 1; end
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic e_en, e_rdy, e_done, e_rs, bus;
    logic [7:0] e_d;
    int u, s, d, off, b;
    if (rst_n) begin
      e_en = 0; e_rdy = 0; e_done = 0; e_rs = 0; e_d = 8'h00; bus = 0;
      if (m_mode == 0) begin
        bus = 1;
        if (m_t >= PW) begin
          u = m_t - PW; s = 0;
          for (int i = 0; i < 4; i++) begin
            d = 1 + EN + ((IB[i] == 8'h01) ? CLR : CMD);
            if (u >= s && u < s + d) begin
              off = u - s; e_en = (off >= 1 && off <= EN); e_d = IB[i];
            end
            s += d;
          end
        end
      end else if (m_mode == 1) begin
        e_rdy = 1;
      end else if (m_t < WRITE_CYC) begin
        b = m_t / BYTE_CYC; off = m_t % BYTE_CYC; bus = 1;
        e_en = (off >= 1 && off <= EN);
        e_rs = (b > 0);
        e_d  = (b == 0) ? (8'h80 | 8'(COL)) : m_chars[8*(6-b) +: 8];
      end else begin
        e_done = 1;
      end
      chk("en", 32'(lcd_en), 32'(e_en));
      chk("ready", 32'(ready), 32'(e_rdy));
      chk("done", 32'(done), 32'(e_done));
      chk("rw", 32'(lcd_rw), 32'(1'b0));
      if (bus) begin
        chk("rs", 32'(lcd_rs), 32'(e_rs));
        chk("data", 32'(lcd_data), 32'(e_d));
      end
    end
  end

  // strobe / done log
  logic       prev_en = 1'b0;
  logic [8:0] strobes[$];
  int         done_at[$];
  int         cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) prev_en <= 1'b0;
    else begin
      if (lcd_en && !prev_en) strobes.push_back({lcd_rs, lcd_data});
      if (done) done_at.push_back(cyc);
      prev_en <= lcd_en;
    end
  end

  task automatic init_and_check(input string tag);
    int c, base;
    base = strobes.size();
    rst_n = 1'b1;
    c = 0;
    while (!ready && c < 200) begin
      @(negedge clk); c++;
      start = (c == 5 || c == 20 || c == 38);
    end
    start = 1'b0;
    chk({tag, "_ready_rise"}, 32'(c), 32'd42);
    chk({tag, "_init_strobes"}, 32'(strobes.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < strobes.size())
        chk({tag, "_init_byte"}, 32'(strobes[base + i]), {23'd0, 1'b0, IB[i]});
  endtask

  logic [8:0] w_exp [7];
  initial begin
    int base, done_k, n0, c;
    w_exp = '{9'h085, 9'h120, 9'h157, 9'h141, 9'h154, 9'h145, 9'h152};
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(lcd_en), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_rw", 32'(lcd_rw), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    init_and_check("boot");

    // single write with a mid-write input change and start re-pulse
    chars = " WATER"; base = strobes.size(); n0 = done_at.size(); done_k = -1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (done && done_k < 0) done_k = k - 1;
      if (k == 10) begin chars = "THANKS"; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    chk("write_done_cycle", 32'(done_k), 32'd49);
    chk("write_done_count", 32'(done_at.size() - n0), 32'd1);
    chk("write_strobes", 32'(strobes.size() - base), 32'd7);
    for (int i = 0; i < 7; i++)
      if (base + i < strobes.size())
        chk("write_byte", 32'(strobes[base + i]), 32'(w_exp[i]));

    // back-to-back with start held
    chars = "ABCDEF"; n0 = done_at.size(); c = 0;
    start = 1'b1;
    while (done_at.size() - n0 < 3 && c < 3 * 51 + 20) begin @(negedge clk); c++; end
    start = 1'b0;
    chk("b2b_done_count", 32'(done_at.size() - n0), 32'd3);
    if (done_at.size() - n0 >= 3) begin
      chk("b2b_gap1", 32'(done_at[n0+1] - done_at[n0]), 32'd51);
      chk("b2b_gap2", 32'(done_at[n0+2] - done_at[n0+1]), 32'd51);
    end
    repeat (5) @(negedge clk);

    // reset during the strobe of the fourth byte of the write
    chars = " WATER";
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0;
    while (!(m_mode == 2 && m_t == 22) && c < 100) begin @(negedge clk); c++; end
    chk("char3_en", 32'(lcd_en), 32'd1);
    chk("char3_data", 32'(lcd_data), 32'h41);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", 32'(lcd_en), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    repeat (3) @(negedge clk);
    init_and_check("rerun");
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
